mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL be the maximum number of REQ cycles waited for bus_ready before abort.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be asynchronous, active-low.
REQ-004 req_read  input  1  load request from the execute stage.
REQ-005 req_write  input  1  store request from the execute stage.
REQ-006 funct3  input  3  access size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 address  input  32  byte address from the execute stage.
REQ-008 write_data  input  32  store data, low-aligned.
REQ-009 read_data  output  32  load data, right-shifted to bit 0; execute stage sign/zero-extends.
REQ-010 wait_sig  output  1  stall request to the execute stage.
REQ-011 misalign_err  output  1  misaligned-access flag, valid in DONE.
REQ-012 access_err  output  1  bus error or timeout flag, valid in DONE.
REQ-013 bus_valid  output  1;  bus_we  output  1;  bus_addr  output  32;  bus_wdata  output  32;  bus_wstrb  output  4 -- word bus request.
REQ-014 bus_ready  input  1;  bus_rdata  input  32;  bus_err  input  1 -- bus response.

Function
REQ-015 FSM states SHALL be IDLE, REQ, DONE.
REQ-016 IDLE with req_read or req_write: wait_sig SHALL be 1 combinationally the same cycle; operands latched; aligned -> REQ, misaligned -> DONE with misalign_err=1, no bus cycle.
REQ-017 Misaligned: H/HU with address[0]=1; W with address[1:0]!=00; B/BU never misaligned.
REQ-018 req_read and req_write both high SHALL perform a write only.
REQ-019 REQ: bus_valid=1, bus_addr={addr[31:2],2'b00}, bus_we=write, all bus outputs SHALL be stable until bus_ready.
REQ-020 bus_wstrb: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111; reads SHALL drive 0000.
REQ-021 bus_wdata SHALL be write_data << 8*addr[1:0].
REQ-022 REQ with bus_ready=1: read data register <- bus_rdata >> 8*addr[1:0]; access_err <- bus_err; -> DONE.
REQ-023 Timeout counter SHALL clear on REQ entry, increment each REQ cycle without bus_ready; on reaching TIMEOUT_CYCLES: bus_valid drops, access_err=1, read_data=0, -> DONE.
REQ-024 DONE: wait_sig=0 for exactly one cycle, read_data holds captured value, then -> IDLE unconditionally.
REQ-025 wait_sig SHALL be 1 in REQ and 0 in IDLE without request.
REQ-026 Minimum load/store latency SHALL be 3 cycles (IDLE, REQ with bus_ready, DONE).
REQ-027 read_data, misalign_err, access_err SHALL be 0 outside DONE; on any error read_data SHALL be 0.
REQ-028 Stores SHALL leave read_data 0.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, bus_valid=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, wait_sig=0, read_data=0, both error flags 0, counter 0.
REQ-030 Reset asserted mid-REQ SHALL abandon the transaction; no retry after release.
REQ-031 First request SHALL be accepted on the first clock edge after rst_n deasserts.

Structure
REQ-032 Package riscv_mem_pkg SHALL hold the state enum, funct3 size constants and TIMEOUT_CYCLES default.
REQ-033 One sub-module mem_lane_align SHALL implement strobe generation and read/write byte-lane shifting combinationally.

Verification
REQ-034 SW addr 0x1006 -> no bus_valid, DONE next cycle with misalign_err=1, wait_sig low one cycle.
REQ-035 SB addr 0x2003 data 0x000000AB, ready immediate -> bus_addr 0x2000, wstrb 1000, wdata 0xAB000000, DONE cycle 3.
REQ-036 LH addr 0x3002, bus_rdata 0xBEEF1234, ready after 4 cycles -> read_data 0x0000BEEF, wait_sig high 5 cycles.
REQ-037 LW addr 0x4000, bus_ready never, TIMEOUT_CYCLES=8 -> bus_valid dropped after 8 REQ cycles, access_err=1, read_data 0.
REQ-038 LW in REQ, rst_n pulsed low -> bus_valid 0 same cycle, IDLE, no DONE; next request runs normally.
REQ-039 req_read=req_write=1 SW addr 0x5000 -> bus_we=1, wstrb 1111, read_data 0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the load/store memory access unit.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    // Access size codes carried on funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    // Signedness is the execute stage's business; only the width matters here.
    function automatic logic [1:0] size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_of = SZ_B;
            F3_H, F3_HU: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = offset[0];
            default: is_misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between low-aligned core data and the 32-bit word bus.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        we,
    input  logic [31:0] write_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [4:0] shamt;

    assign shamt = {offset, 3'b000};

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wstrb = 4'b0000;
        if (we) begin
            case (size)
                SZ_B:    wstrb = 4'b0001 << offset;
                SZ_H:    wstrb = 4'b0011 << offset;
                default: wstrb = 4'b1111;
            endcase
        end
    end

    assign wdata = write_data << shamt;
    assign rdata = bus_rdata >> shamt;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: stalls the execute stage while one word-bus transaction runs.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        wait_sig,
    output logic        misalign_err,
    output logic        access_err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state, next_state;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0] rdata_q;
    logic        misalign_q;
    logic        access_q;

    logic        req_any;
    logic        misaligned_in;
    logic        timeout_hit;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    assign req_any       = req_read | req_write;
    assign misaligned_in = is_misaligned(size_of(funct3), address[1:0]);
    assign timeout_hit   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    mem_lane_align u_lane_align (
        .size       (size_q),
        .offset     (addr_q[1:0]),
        .we         (we_q),
        .write_data (wdata_q),
        .bus_rdata  (bus_rdata),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .rdata      (lane_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Bus and result outputs are decoded from state so reset clears them immediately.
    always_comb begin
        next_state   = state;
        wait_sig     = 1'b0;
        bus_valid    = 1'b0;
        bus_we       = 1'b0;
        bus_addr     = 32'h0;
        bus_wdata    = 32'h0;
        bus_wstrb    = 4'b0000;
        read_data    = 32'h0;
        misalign_err = 1'b0;
        access_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    wait_sig   = 1'b1;
                    next_state = misaligned_in ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                wait_sig  = 1'b1;
                bus_valid = 1'b1;
                bus_we    = we_q;
                bus_addr  = {addr_q[31:2], 2'b00};
                bus_wdata = lane_wdata;
                bus_wstrb = lane_wstrb;
                if (bus_ready || timeout_hit) next_state = ST_DONE;
            end
            ST_DONE: begin
                read_data    = rdata_q;
                misalign_err = misalign_q;
                access_err   = access_q;
                next_state   = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            size_q     <= SZ_B;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            cnt        <= '0;
            rdata_q    <= 32'h0;
            misalign_q <= 1'b0;
            access_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        we_q       <= req_write;
                        size_q     <= size_of(funct3);
                        addr_q     <= address;
                        wdata_q    <= write_data;
                        cnt        <= '0;
                        rdata_q    <= 32'h0;
                        misalign_q <= misaligned_in;
                        access_q   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (bus_ready) begin
                        rdata_q  <= (we_q || bus_err) ? 32'h0 : lane_rdata;
                        access_q <= bus_err;
                    end else if (timeout_hit) begin
                        rdata_q  <= 32'h0;
                        access_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit with an 8-cycle bus timeout.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_read;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        wait_sig;
    logic        misalign_err;
    logic        access_err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int total  = 0;
    int passed = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_read     (req_read),
        .req_write    (req_write),
        .funct3       (funct3),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .wait_sig     (wait_sig),
        .misalign_err (misalign_err),
        .access_err   (access_err),
        .bus_valid    (bus_valid),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          ready_at;   // REQ cycle on which bus_ready rises; 0 = never
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        bit          e_we;
        logic [31:0] e_read;
        bit          e_mis;
        bit          e_acc;
        int          e_waits;
        int          e_bus;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(
        input string nm, input bit rd, input bit wr, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
        input bit err, input int ready_at, input logic [31:0] e_addr, input logic [3:0] e_strb,
        input logic [31:0] e_wdata, input bit e_we, input logic [31:0] e_read,
        input bit e_mis, input bit e_acc, input int e_waits, input int e_bus);
        vec_t v;
        v.nm = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.ready_at = ready_at; v.e_addr = e_addr;
        v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_we = e_we; v.e_read = e_read;
        v.e_mis = e_mis; v.e_acc = e_acc; v.e_waits = e_waits; v.e_bus = e_bus;
        return v;
    endfunction

    // Called between clock edges with the unit idle; the request is taken on the next rising edge.
    task automatic run_vec(input vec_t v);
        int  waits;
        int  buscyc;
        bit  done;
        req_read   = v.rd;
        req_write  = v.wr;
        funct3     = v.f3;
        address    = v.addr;
        write_data = v.wdata;
        #1;
        check({v.nm, " wait_comb"}, 32'(wait_sig), 32'd1);
        check({v.nm, " idle_no_bus"}, 32'(bus_valid), 32'd0);
        @(posedge clk); #1;
        req_read   = 1'b0;
        req_write  = 1'b0;
        funct3     = 3'b010;
        address    = 32'hFFFF_FFFF;
        write_data = 32'hFFFF_FFFF;
        waits  = 1;
        buscyc = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!wait_sig) begin
                done      = 1'b1;
                bus_ready = 1'b0;
                check({v.nm, " bus_in_done"}, 32'(bus_valid), 32'd0);
                check({v.nm, " read_data"}, read_data, v.e_read);
                check({v.nm, " misalign_err"}, 32'(misalign_err), 32'(v.e_mis));
                check({v.nm, " access_err"}, 32'(access_err), 32'(v.e_acc));
            end else begin
                waits++;
                if (bus_valid) begin
                    buscyc++;
                    check({v.nm, " bus_addr"}, bus_addr, v.e_addr);
                    check({v.nm, " bus_we"}, 32'(bus_we), 32'(v.e_we));
                    check({v.nm, " bus_wstrb"}, 32'(bus_wstrb), 32'(v.e_strb));
                    check({v.nm, " bus_wdata"}, bus_wdata, v.e_wdata);
                    bus_ready = (buscyc == v.ready_at);
                    bus_rdata = v.rdata;
                    bus_err   = v.err;
                end else begin
                    bus_ready = 1'b0;
                end
            end
        end
        bus_ready = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = 32'h0;
        if (!done) check({v.nm, " done_reached"}, 32'd0, 32'd1);
        check({v.nm, " wait_cycles"}, 32'(waits), 32'(v.e_waits));
        check({v.nm, " bus_cycles"}, 32'(buscyc), 32'(v.e_bus));
        @(posedge clk); #1;
        @(negedge clk);
        check({v.nm, " idle_wait"}, 32'(wait_sig), 32'd0);
        check({v.nm, " idle_read_data"}, read_data, 32'h0);
        check({v.nm, " idle_errs"}, {30'd0, misalign_err, access_err}, 32'h0);
    endtask

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            name        rd wr f3      addr          wdata         rdata         er rdy e_addr        strb     e_wdata       we e_read        mis acc wt bus
        vecs[0]  = mk("sw_mis",   0, 1, 3'b010, 32'h0000_1006, 32'h1111_2222, 32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1, 0, 1, 0);
        vecs[1]  = mk("sb_2003",  0, 1, 3'b000, 32'h0000_2003, 32'h0000_00AB, 32'h0,        0, 1, 32'h0000_2000, 4'b1000, 32'hAB00_0000, 1, 32'h0,        0, 0, 2, 1);
        vecs[2]  = mk("lh_3002",  1, 0, 3'b001, 32'h0000_3002, 32'h0,        32'hBEEF_1234, 0, 4, 32'h0000_3000, 4'b0000, 32'h0,        0, 32'h0000_BEEF, 0, 0, 5, 4);
        vecs[3]  = mk("lw_tmo",   1, 0, 3'b010, 32'h0000_4000, 32'h0,        32'h1234_5678, 0, 0, 32'h0000_4000, 4'b0000, 32'h0,        0, 32'h0,        0, 1, 9, 8);
        vecs[4]  = mk("rw_sw",    1, 1, 3'b010, 32'h0000_5000, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1, 32'h0000_5000, 4'b1111, 32'h1234_5678, 1, 32'h0,        0, 0, 2, 1);
        vecs[5]  = mk("lb_6001",  1, 0, 3'b000, 32'h0000_6001, 32'h0,        32'h1122_3344, 0, 2, 32'h0000_6000, 4'b0000, 32'h0,        0, 32'h0011_2233, 0, 0, 3, 2);
        vecs[6]  = mk("lw_err",   1, 0, 3'b010, 32'h0000_7000, 32'h0,        32'hDEAD_BEEF, 1, 1, 32'h0000_7000, 4'b0000, 32'h0,        0, 32'h0,        0, 1, 2, 1);
        vecs[7]  = mk("sh_8002",  0, 1, 3'b001, 32'h0000_8002, 32'h0000_CAFE, 32'h0,        0, 3, 32'h0000_8000, 4'b1100, 32'hCAFE_0000, 1, 32'h0,        0, 0, 4, 3);
        vecs[8]  = mk("lhu_mis",  1, 0, 3'b101, 32'h0000_9001, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1, 0, 1, 0);
        vecs[9]  = mk("lbu_a003", 1, 0, 3'b100, 32'h0000_A003, 32'h0,        32'h8000_0000, 0, 1, 32'h0000_A000, 4'b0000, 32'h0,        0, 32'h0000_0080, 0, 0, 2, 1);
        vecs[10] = mk("sw_err",   0, 1, 3'b010, 32'h0000_B000, 32'h55AA_55AA, 32'h0,        1, 2, 32'h0000_B000, 4'b1111, 32'h55AA_55AA, 1, 32'h0,        0, 1, 3, 2);
        vecs[11] = mk("lh_c000",  1, 0, 3'b001, 32'h0000_C000, 32'h0,        32'h1234_ABCD, 0, 1, 32'h0000_C000, 4'b0000, 32'h0,        0, 32'h1234_ABCD, 0, 0, 2, 1);
        vecs[12] = mk("lw_mis2",  1, 0, 3'b010, 32'h0000_E002, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1, 0, 1, 0);
        vecs[13] = mk("sh_0000",  0, 1, 3'b001, 32'h0000_D000, 32'hFFFF_8001, 32'h0,        0, 1, 32'h0000_D000, 4'b0011, 32'hFFFF_8001, 1, 32'h0,        0, 0, 2, 1);

        rst_n      = 1'b0;
        req_read   = 1'b0;
        req_write  = 1'b0;
        funct3     = 3'b000;
        address    = 32'h0;
        write_data = 32'h0;
        bus_ready  = 1'b0;
        bus_rdata  = 32'h0;
        bus_err    = 1'b0;
        #1;
        check("rst wait_sig", 32'(wait_sig), 32'd0);
        check("rst bus_valid", 32'(bus_valid), 32'd0);
        check("rst bus_addr", bus_addr, 32'h0);
        check("rst bus_wdata", bus_wdata, 32'h0);
        check("rst bus_strb_we", {27'd0, bus_wstrb, bus_we}, 32'h0);
        check("rst read_data", read_data, 32'h0);
        check("rst errs", {30'd0, misalign_err, access_err}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First vector starts right after release: accepted on the first rising edge.
        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Reset in the middle of a load: bus released at once, no completion, no retry.
        @(posedge clk); #1;
        req_read = 1'b1;
        funct3   = 3'b010;
        address  = 32'h0000_F000;
        @(posedge clk); #1;
        req_read = 1'b0;
        @(negedge clk);
        check("midrst bus_valid_before", 32'(bus_valid), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst bus_valid", 32'(bus_valid), 32'd0);
        check("midrst wait_sig", 32'(wait_sig), 32'd0);
        check("midrst bus_addr", bus_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst quiet", {29'd0, bus_valid, wait_sig, access_err}, 32'h0);
            check("postrst read_data", read_data, 32'h0);
        end
        run_vec(vecs[5]);
        run_vec(vecs[1]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
